instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/instruction_fetch.sv | 95 +++++++++
 tb/tb_instruction_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch pipeline.
// Holds data width, instruction size, NOP encoding, reset PC and the IF/ID bundle.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0004;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

  typedef enum logic [1:0] {
    FETCH_ADV,
    FETCH_HOLD,
    FETCH_REDIRECT
  } fetch_act_e;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] addr
  );
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word addresses to a registered imem and fills IF/ID.
// Ports: clk, rst_n (async low), stall_i, branch_taken_i/branch_target_i, imem_addr_o,
//        imem_word_i (one edge after address), if_id_instr_o/if_id_pc_o/if_id_valid_o.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_word_i,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic            if_id_valid_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            resp_valid_q, resp_valid_d;
  if_id_t          if_id_q, if_id_d;
  fetch_act_e      act;

  // Low target bits are dropped: fetch is always word aligned.
  logic unused_tgt_lo;
  assign unused_tgt_lo = ^branch_target_i[1:0];

  // Redirect outranks stall.
  always_comb begin
    if (branch_taken_i) begin
      act = FETCH_REDIRECT;
    end else if (stall_i) begin
      act = FETCH_HOLD;
    end else begin
      act = FETCH_ADV;
    end
  end

  // While held, re-issue the pending address so the
  // memory re-presents the same word on the next cycle.
  assign imem_addr_o =
    (act == FETCH_HOLD) ? resp_pc_q : pc_q;

  always_comb begin
    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    if_id_d      = if_id_q;
    unique case (act)
      FETCH_REDIRECT: begin
        pc_d          = word_align(branch_target_i);
        resp_valid_d  = 1'b0;
        if_id_d.valid = 1'b0;
        if_id_d.instr = NOP_INSTR;
      end
      FETCH_HOLD: begin
      end
      FETCH_ADV: begin
        pc_d          = pc_q + XLEN'(INSTR_BYTES);
        resp_pc_d     = pc_q;
        resp_valid_d  = 1'b1;
        if_id_d.pc    = resp_pc_q;
        if_id_d.valid = resp_valid_q;
        if_id_d.instr = resp_valid_q ? imem_word_i
                                     : NOP_INSTR;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      resp_valid_q  <= 1'b0;
      if_id_q.instr <= NOP_INSTR;
      if_id_q.pc    <= '0;
      if_id_q.valid <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      if_id_q      <= if_id_d;
    end
  end

  assign if_id_instr_o = if_id_q.instr;
  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_valid_o = if_id_q.valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: two instances (default and wrapping reset PC).
// Expected IF/ID words are queued by stimulus and popped when decode consumes a slot.
module tb_instruction_fetch;
  import riscv_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] tgt;

  logic [31:0] addr_a, word_a, instr_a, pc_a;
  logic        valid_a;
  logic [31:0] addr_b, word_b, instr_b, pc_b;
  logic        valid_b;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instruction_fetch u_a (
    .clk(clk), .rst_n(rst_n), .stall_i(stall),
    .branch_taken_i(br), .branch_target_i(tgt),
    .imem_addr_o(addr_a), .imem_word_i(word_a),
    .if_id_instr_o(instr_a), .if_id_pc_o(pc_a),
    .if_id_valid_o(valid_a)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_b (
    .clk(clk), .rst_n(rst_n), .stall_i(stall),
    .branch_taken_i(br), .branch_target_i(tgt),
    .imem_addr_o(addr_b), .imem_word_i(word_b),
    .if_id_instr_o(instr_b), .if_id_pc_o(pc_b),
    .if_id_valid_o(valid_b)
  );

  function automatic logic [31:0] mem_f(
    input logic [31:0] a
  );
    case (a)
      32'd4:   return 32'h0010_0093;
      32'd8:   return 32'h0020_0113;
      32'd12:  return 32'h0000_0033;
      32'd80:  return 32'h0040_0F93;
      default: return 32'h0000_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    word_a <= mem_f(addr_a);
    word_b <= mem_f(addr_b);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] p,
                        input logic [31:0] i);
    exp_t e;
    e.pc = p;
    e.instr = i;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] p,
                        input logic [31:0] i);
    exp_t e;
    e.pc = p;
    e.instr = i;
    qb.push_back(e);
  endtask

  // Decode consumes a slot on a cycle where it is valid and not stalled.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_a && !stall) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL sb_a_extra got pc=%h instr=%h want none",
                 pc_a, instr_a);
      end else begin
        exp_t e;
        e = qa.pop_front();
        if (pc_a !== e.pc || instr_a !== e.instr) begin
          errors++;
          $display("FAIL sb_a got pc=%h instr=%h want pc=%h instr=%h",
                   pc_a, instr_a, e.pc, e.instr);
        end
      end
    end
    if (rst_n === 1'b1 && valid_b && !stall && qb.size() != 0) begin
      exp_t e;
      checks++;
      e = qb.pop_front();
      if (pc_b !== e.pc || instr_b !== e.instr) begin
        errors++;
        $display("FAIL sb_b got pc=%h instr=%h want pc=%h instr=%h",
                 pc_b, instr_b, e.pc, e.instr);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    br    = 1'b0;
    tgt   = '0;
    step();
    step();
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_instr", instr_a, NOP_INSTR);
    chk("rst_pc", pc_a, 32'd0);
    chk("rst_addr", addr_a, 32'd4);
    chk("rst_addr_b", addr_b, 32'hFFFF_FFFC);

    push_a(32'd4,  32'h0010_0093);
    push_a(32'd8,  32'h0020_0113);
    push_a(32'd12, 32'h0000_0033);
    push_a(32'd16, 32'h0000_0000);
    push_a(32'd80, 32'h0040_0F93);
    push_a(32'h4C, 32'h0000_0000);
    push_a(32'h50, 32'h0040_0F93);
    push_b(32'hFFFF_FFFC, 32'h0);
    push_b(32'h0000_0000, 32'h0);
    push_b(32'h0000_0004, 32'h0010_0093);

    rst_n = 1'b1;
    step();
    chk("lat_e1_valid", {31'd0, valid_a}, 32'd0);
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_addr", addr_a, 32'd12);
      chk("stall_pc", pc_a, 32'd8);
      chk("stall_instr", instr_a, 32'h0020_0113);
      step();
    end
    stall = 1'b0;
    step();
    step();
    br  = 1'b1;
    tgt = 32'h50;
    step();
    br = 1'b0;
    chk("br1_valid", {31'd0, valid_a}, 32'd0);
    chk("br1_instr", instr_a, NOP_INSTR);
    step();
    chk("br2_valid", {31'd0, valid_a}, 32'd0);
    chk("br2_instr", instr_a, NOP_INSTR);
    step();
    step();
    br    = 1'b1;
    stall = 1'b1;
    tgt   = 32'h4E;
    step();
    br    = 1'b0;
    stall = 1'b0;
    #1;
    chk("brst_addr", addr_a, 32'h4C);
    step();
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, valid_a}, 32'd0);
    chk("mid_rst_addr", addr_a, 32'd4);
    chk("mid_rst_instr", instr_a, NOP_INSTR);
    push_a(32'd4,  32'h0010_0093);
    push_a(32'd8,  32'h0020_0113);
    push_a(32'd12, 32'h0000_0033);
    step();
    rst_n = 1'b1;
    step();
    chk("rst2_e1_valid", {31'd0, valid_a}, 32'd0);
    step();
    step();
    step();
    @(negedge clk);
    #1;
    stall = 1'b1;
    chk("qa_left", qa.size(), 32'd0);
    chk("qb_left", qb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
